cla8_handshake_stage: RTL and testbench

- Registered valid/ready stage that wraps the external 8-bit carry-lookahead adder core.
- Captures an operand pair plus carry-in and drives them, held stable, onto the adder inputs.
- Waits a fixed settle time sized to the gate-delay model, then captures sum/carry-out and presents them on a valid/ready output port.
- Sits directly upstream (operand feed) and downstream (result capture) of the adder core in the datapath.

---
 rtl/cla8_pkg.sv | 25 ++
 rtl/cla8_settle_timer.sv | 33 +++
 rtl/cla8_handshake_stage.sv | 165 ++++++++++++++++
 tb/tb_cla8_handshake_stage.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/cla8_pkg.sv
// Shared types and constants for the CLA8 handshake stage: FSM states,
// operand bundle, counter width and the signed-overflow helper.
package cla8_pkg;

  localparam int CLA_WIDTH    = 8;
  localparam int SETTLE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  typedef struct packed {
    logic [CLA_WIDTH-1:0] a;
    logic [CLA_WIDTH-1:0] b;
    logic                 cin;
  } operand_t;

  // Two's-complement overflow: like-signed operands producing a result of the other sign.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic sum_msb);
    return (a_msb == b_msb) && (sum_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla8_settle_timer.sv
// Loadable down-counter with zero flag; times how long operands are held
// on the adder core before the result is captured.
module cla8_settle_timer
  import cla8_pkg::*;
#(
  parameter int CNT_W = SETTLE_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             count,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Load has priority; counting stops at zero rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= CNT_W'(0);
    end else if (load) begin
      cnt_r <= load_val;
    end else if (count && (cnt_r != CNT_W'(0))) begin
      cnt_r <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == CNT_W'(0));

endmodule

// File: rtl/cla8_handshake_stage.sv
// Valid/ready wrapper around the external 8-bit CLA core: holds operands for
// SETTLE_CYCLES, then captures the result. Optional out_ovf port: CLA8_OVERFLOW_EN.
module cla8_handshake_stage
  import cla8_pkg::*;
#(
  parameter int WIDTH         = CLA_WIDTH,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] cla_a,
  output logic [WIDTH-1:0] cla_b,
  output logic             cla_cin,
  input  logic [WIDTH-1:0] cla_sum,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
`ifdef CLA8_OVERFLOW_EN
  ,
  output logic             out_ovf
`endif
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15) || (WIDTH != CLA_WIDTH)) begin : g_bad_cfg
    $error("cla8_handshake_stage: SETTLE_CYCLES must be 1..15 and WIDTH must equal CLA_WIDTH");
  end

  localparam logic [SETTLE_CNT_W-1:0] LOAD_VAL = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_r, state_nxt_s;
  operand_t         ops_r;
  logic [WIDTH-1:0] out_sum_r;
  logic             out_cout_r;
  logic             out_valid_r;
  logic             accept_s, capture_s, release_s;
  logic             tmr_zero_s;

  cla8_settle_timer #(.CNT_W(SETTLE_CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_s),
    .load_val (LOAD_VAL),
    .count    (state_r == SETTLE),
    .zero     (tmr_zero_s)
  );

  // Next-state decode and the three transaction events.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    capture_s   = 1'b0;
    release_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETTLE: begin
        if (tmr_zero_s) begin
          capture_s   = 1'b1;
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      HOLD: begin
        if (out_ready) begin
          release_s   = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand registers feeding the core; they change only on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ops_r <= '{a: CLA_WIDTH'(0), b: CLA_WIDTH'(0), cin: 1'b0};
    end else if (accept_s) begin
      ops_r <= '{a: in_a, b: in_b, cin: in_cin};
    end else begin
      ops_r <= ops_r;
    end
  end

  // Result capture; values persist after the handshake, out_valid qualifies them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_sum_r  <= WIDTH'(0);
      out_cout_r <= 1'b0;
    end else if (capture_s) begin
      out_sum_r  <= cla_sum;
      out_cout_r <= cla_cout;
    end else begin
      out_sum_r  <= out_sum_r;
      out_cout_r <= out_cout_r;
    end
  end

  // Output valid flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
    end else if (capture_s) begin
      out_valid_r <= 1'b1;
    end else if (release_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

`ifdef CLA8_OVERFLOW_EN
  logic out_ovf_r;

  // Signed overflow flag, captured alongside the sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_ovf_r <= 1'b0;
    end else if (capture_s) begin
      out_ovf_r <= signed_ovf(ops_r.a[CLA_WIDTH-1], ops_r.b[CLA_WIDTH-1], cla_sum[WIDTH-1]);
    end else begin
      out_ovf_r <= out_ovf_r;
    end
  end

  assign out_ovf = out_ovf_r;
`endif

  assign in_ready  = (state_r == IDLE);
  assign busy      = (state_r == SETTLE) || (state_r == HOLD);
  assign cla_a     = ops_r.a;
  assign cla_b     = ops_r.b;
  assign cla_cin   = ops_r.cin;
  assign out_sum   = out_sum_r;
  assign out_cout  = out_cout_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_cla8_handshake_stage.sv
// Self-checking bench for cla8_handshake_stage: transaction-level reference model,
// an adder-core model that is wrong until operands have settled, and random traffic.
module tb_cla8_handshake_stage;

  localparam int W = 8;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         in_cin;
  logic [W-1:0] cla_a, cla_b;
  logic         cla_cin;
  logic [W-1:0] cla_sum;
  logic         cla_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
`ifdef CLA8_OVERFLOW_EN
  logic         out_ovf;
`endif

  always #5 clk = ~clk;

  cla8_handshake_stage #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .cla_a     (cla_a),
    .cla_b     (cla_b),
    .cla_cin   (cla_cin),
    .cla_sum   (cla_sum),
    .cla_cout  (cla_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
`ifdef CLA8_OVERFLOW_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  // Adder core model: result is only correct once inputs have been stable for S-1 edges.
  logic [16:0] core_prev   = 17'h1ffff;
  int          core_stable = 0;
  logic [8:0]  core_true;

  always @(negedge clk) begin
    if ({cla_a, cla_b, cla_cin} !== core_prev) begin
      core_prev   = {cla_a, cla_b, cla_cin};
      core_stable = 0;
    end else if (core_stable < 1000) begin
      core_stable++;
    end
  end

  assign core_true           = {1'b0, cla_a} + {1'b0, cla_b} + {8'd0, cla_cin};
  assign {cla_cout, cla_sum} = (core_stable >= S - 1) ? core_true : ~core_true;

  // Reference model state
  bit         m_busy;
  int         m_cnt;
  logic [7:0] m_a, m_b, m_sum;
  logic       m_cin, m_cout, m_ovf;

  int tests = 0;
  int fails = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: decide handshakes from the model, advance, then compare everything.
  task automatic step();
    bit         fin, fout;
    logic [7:0] la, lb;
    logic       lcin;
    int         s, ss;
    fin  = rst_n && in_valid && !m_busy;
    fout = rst_n && m_busy && (m_cnt >= S) && out_ready;
    la = in_a; lb = in_b; lcin = in_cin;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_busy = 1'b0; m_cnt = 0;
      m_a = 8'h00; m_b = 8'h00; m_cin = 1'b0;
      m_sum = 8'h00; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (fin) begin
      m_busy = 1'b1; m_cnt = 0;
      m_a = la; m_b = lb; m_cin = lcin;
    end else if (m_busy) begin
      if (fout) begin
        m_busy = 1'b0;
      end else begin
        m_cnt++;
        if (m_cnt == S) begin
          s      = int'(m_a) + int'(m_b) + int'(m_cin);
          m_sum  = s[7:0];
          m_cout = (s > 255);
          ss     = int'($signed(m_a)) + int'($signed(m_b)) + int'(m_cin);
          m_ovf  = (ss > 127) || (ss < -128);
        end
      end
    end
    check_eq("in_ready",  {31'd0, in_ready},  {31'd0, !m_busy});
    check_eq("busy",      {31'd0, busy},      {31'd0, m_busy});
    check_eq("out_valid", {31'd0, out_valid}, {31'd0, (m_busy && (m_cnt >= S))});
    check_eq("out_sum",   {24'd0, out_sum},   {24'd0, m_sum});
    check_eq("out_cout",  {31'd0, out_cout},  {31'd0, m_cout});
    check_eq("cla_a",     {24'd0, cla_a},     {24'd0, m_a});
    check_eq("cla_b",     {24'd0, cla_b},     {24'd0, m_b});
    check_eq("cla_cin",   {31'd0, cla_cin},   {31'd0, m_cin});
`ifdef CLA8_OVERFLOW_EN
    check_eq("out_ovf",   {31'd0, out_ovf},   {31'd0, m_ovf});
`endif
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin);
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    m_busy = 1'b0; m_cnt = 0;
    m_a = 8'h00; m_b = 8'h00; m_cin = 1'b0;
    m_sum = 8'h00; m_cout = 1'b0; m_ovf = 1'b0;

    // Reset with in_valid asserted: nothing may be captured
    rst_n = 1'b0; in_valid = 1'b1; in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b1; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1; in_valid = 1'b0;
    step();

    // Basic add and carry wrap
    out_ready = 1'b1;
    send(8'h35, 8'h42, 1'b0);
    repeat (S + 2) step();
    check_eq("basic_sum", {24'd0, out_sum}, 32'h77);
    send(8'hFF, 8'h01, 1'b1);
    repeat (S + 2) step();
    check_eq("wrap_sum", {24'd0, out_sum}, 32'h01);
    check_eq("wrap_cout", {31'd0, out_cout}, 32'h1);

    // Backpressure in HOLD with in_valid pulses
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0);
    repeat (S + 10) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a     = 8'($urandom);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) step();

    // Reset during settle abandons the transaction
    send(8'h10, 8'h20, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (S + 2) step();
    check_eq("rst_mid_sum", {24'd0, out_sum}, 32'h00);

    // Signed overflow
    send(8'h7F, 8'h01, 1'b0);
    repeat (S + 2) step();
    check_eq("ovf_sum", {24'd0, out_sum}, 32'h80);

    // Random traffic
    repeat (400) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      in_cin    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
